// File: rtl/load_unit_mc_if.sv
// load_unit_mc_if: request/grant/rvalid read channel between the load unit
// and a word-organised data memory.
//   mem_req    : read request, held with mem_addr until granted
//   mem_addr   : word address (ADDR_W bits)
//   mem_gnt    : memory accepted the request
//   mem_rvalid : read data valid (earliest the cycle after the grant)
//   mem_rdata  : 32-bit read word
// master = load unit side, slave = memory side.
interface load_unit_mc_if #(
  parameter int ADDR_W = 10
);
  logic              mem_req;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_gnt;
  logic              mem_rvalid;
  logic [31:0]       mem_rdata;

  modport master (output mem_req, mem_addr, input mem_gnt, mem_rvalid, mem_rdata);
  modport slave  (input mem_req, mem_addr, output mem_gnt, mem_rvalid, mem_rdata);
endinterface

// File: rtl/load_unit_mc.sv
// load_unit_mc: multi-cycle RV32 load unit (LB/LH/LW/LBU/LHU).
// Accepts one load from the execute stage, issues a word read on the memory
// channel, extracts and extends the addressed lane and writes it back for one
// cycle. Faults pulse for one cycle with a cause code.
//
// Ports:
//   i_clk, i_rst            : clock, synchronous active-high reset
//   ld_valid/ld_ready       : load request handshake (ld_ready = unit idle)
//   ld_funct3, rs1_val, imm : load type and address operands
//   rd_in                   : destination register
//   stall_pc, stall_other_exec : pipeline stalls while a load is in flight
//   mem                     : memory read channel (load_unit_mc_if.master)
//   rd_write_control, rd_out, rd_write_val : register-file write-back
//   ld_fault, ld_cause      : fault pulse, 01 misalign / 10 timeout / 11 illegal
//
// Optional build macro LOAD_MISALIGN_TRAP_EN: when defined, misaligned LH/LHU/LW
// fault with cause 01 instead of accessing memory.
module load_unit_mc #(
  parameter int ADDR_W      = 10,
  parameter int TIMEOUT_CYC = 64
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  ld_valid,
  input  logic [2:0]            ld_funct3,
  input  logic [31:0]           rs1_val,
  input  logic [31:0]           imm,
  input  logic [4:0]            rd_in,
  output logic                  ld_ready,
  output logic                  stall_pc,
  output logic                  stall_other_exec,
  load_unit_mc_if.master        mem,
  output logic                  rd_write_control,
  output logic [4:0]            rd_out,
  output logic [31:0]           rd_write_val,
  output logic                  ld_fault,
  output logic [1:0]            ld_cause
);
  localparam int CNT_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;

  typedef enum logic [2:0] {IDLE, REQ, WAIT, WB, FAULT} state_e;

  // Only the address bits that reach the memory or pick the lane are kept.
  typedef struct packed {
    logic [ADDR_W+1:0] addr;
    logic [2:0]        funct3;
    logic [4:0]        rd;
  } ld_req_t;

  state_e            state_q, state_d;
  ld_req_t           req_q, req_d;
  logic [31:0]       data_q, data_d;
  logic [1:0]        cause_q, cause_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  logic [ADDR_W+1:0] eff_addr;
  logic              f3_legal, misalign, timeout_hit;
  logic [31:0]       shifted;
  logic [15:0]       half_v;
  logic [31:0]       ext_val;

  assign eff_addr = (ADDR_W+2)'(rs1_val + imm);
  assign f3_legal = (ld_funct3 == 3'b000) || (ld_funct3 == 3'b001) || (ld_funct3 == 3'b010) ||
                    (ld_funct3 == 3'b100) || (ld_funct3 == 3'b101);

`ifdef LOAD_MISALIGN_TRAP_EN
  assign misalign = ((ld_funct3[1:0] == 2'b01) && eff_addr[0]) ||
                    ((ld_funct3[1:0] == 2'b10) && (eff_addr[1:0] != 2'b00));
`else
  assign misalign = 1'b0;
`endif

  // Counter holds the number of WAIT cycles already spent without rvalid.
  assign timeout_hit = (TIMEOUT_CYC != 0) && (cnt_q == CNT_W'(TIMEOUT_CYC - 1));

  // Lane extraction from the returned word using the latched byte offset.
  assign shifted = mem.mem_rdata >> {req_q.addr[1:0], 3'b000};
  assign half_v  = req_q.addr[1] ? mem.mem_rdata[31:16] : mem.mem_rdata[15:0];

  always_comb begin
    ext_val = mem.mem_rdata;
    unique case (req_q.funct3)
      3'b000:  ext_val = {{24{shifted[7]}}, shifted[7:0]};
      3'b100:  ext_val = {24'b0, shifted[7:0]};
      3'b001:  ext_val = {{16{half_v[15]}}, half_v};
      3'b101:  ext_val = {16'b0, half_v};
      default: ext_val = mem.mem_rdata;
    endcase
  end

  always_comb begin
    state_d = state_q;
    req_d   = req_q;
    data_d  = data_q;
    cause_d = cause_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: if (ld_valid) begin
        req_d = '{addr: eff_addr, funct3: ld_funct3, rd: rd_in};
        if (!f3_legal) begin
          state_d = FAULT;
          cause_d = 2'b11;
        end else if (misalign) begin
          state_d = FAULT;
          cause_d = 2'b01;
        end else begin
          state_d = REQ;
        end
      end
      REQ: if (mem.mem_gnt) begin
        state_d = WAIT;
        cnt_d   = '0;
      end
      WAIT: begin
        if (mem.mem_rvalid) begin
          data_d  = ext_val;
          state_d = WB;
        end else if (timeout_hit) begin
          state_d = FAULT;
          cause_d = 2'b10;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      WB, FAULT: state_d = IDLE;
      default:   state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= IDLE;
      req_q   <= '0;
      data_q  <= '0;
      cause_q <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      req_q   <= req_d;
      data_q  <= data_d;
      cause_q <= cause_d;
      cnt_q   <= cnt_d;
    end
  end

  assign ld_ready         = (state_q == IDLE);
  assign stall_other_exec = (state_q != IDLE);
  assign stall_pc         = (state_q != IDLE) || (ld_valid && (state_q == IDLE));
  assign mem.mem_req      = (state_q == REQ);
  assign mem.mem_addr     = (state_q == REQ) ? req_q.addr[ADDR_W+1:2] : '0;
  assign rd_write_control = (state_q == WB) && (req_q.rd != 5'd0);
  assign rd_out           = (state_q == WB) ? req_q.rd : 5'd0;
  assign rd_write_val     = (state_q == WB) ? data_q : 32'd0;
  assign ld_fault         = (state_q == FAULT);
  assign ld_cause         = (state_q == FAULT) ? cause_q : 2'b00;
endmodule

// File: tb/tb_load_unit_mc.sv
// Directed bench for load_unit_mc (TIMEOUT_CYC = 4, ADDR_W = 10).
module tb_load_unit_mc;
  logic        i_clk = 1'b0;
  logic        i_rst;
  logic        ld_valid;
  logic [2:0]  ld_funct3;
  logic [31:0] rs1_val, imm;
  logic [4:0]  rd_in;
  logic        ld_ready, stall_pc, stall_other_exec;
  logic        rd_write_control;
  logic [4:0]  rd_out;
  logic [31:0] rd_write_val;
  logic        ld_fault;
  logic [1:0]  ld_cause;

  int n_vec = 0;
  int n_err = 0;

  load_unit_mc_if #(.ADDR_W(10)) mem ();

  load_unit_mc #(.ADDR_W(10), .TIMEOUT_CYC(4)) dut (
    .i_clk(i_clk), .i_rst(i_rst), .ld_valid(ld_valid), .ld_funct3(ld_funct3),
    .rs1_val(rs1_val), .imm(imm), .rd_in(rd_in), .ld_ready(ld_ready),
    .stall_pc(stall_pc), .stall_other_exec(stall_other_exec), .mem(mem.master),
    .rd_write_control(rd_write_control), .rd_out(rd_out), .rd_write_val(rd_write_val),
    .ld_fault(ld_fault), .ld_cause(ld_cause)
  );

  always #5 i_clk = ~i_clk;

  typedef struct {
    logic [2:0]  f3;
    logic [31:0] rs1;
    logic [31:0] imm;
    logic [4:0]  rd;
    logic [31:0] rdata;
    int          gnt_dly;
    int          rv_dly;
    logic [9:0]  addr;
    logic        flt;
    logic [1:0]  cause;
    logic        wr;
    logic [31:0] val;
  } vec_t;

  vec_t vecs[17];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge i_clk);
    @(negedge i_clk);
  endtask

  task automatic chk_idle(input string nm);
    chk({nm, " ready"}, ld_ready, 1);
    chk({nm, " stall_oe"}, stall_other_exec, 0);
    chk({nm, " stall_pc"}, stall_pc, 0);
    chk({nm, " mem_req"}, mem.mem_req, 0);
    chk({nm, " wr"}, rd_write_control, 0);
    chk({nm, " rd_out"}, rd_out, 0);
    chk({nm, " wval"}, rd_write_val, 0);
    chk({nm, " fault"}, ld_fault, 0);
  endtask

  // Called just after a falling edge with the unit idle; returns likewise,
  // so consecutive calls exercise back-to-back acceptance.
  task automatic run_vec(input int k, input vec_t v);
    string nm;
    nm = $sformatf("v%0d", k);
    ld_valid = 1'b1; ld_funct3 = v.f3; rs1_val = v.rs1; imm = v.imm; rd_in = v.rd;
    #1;
    chk({nm, " ready_acc"}, ld_ready, 1);
    chk({nm, " stall_pc_acc"}, stall_pc, 1);
    tick();
    ld_valid = 1'b0; rs1_val = 32'h0; imm = 32'h0; rd_in = 5'd0;
    #1;
    if (v.flt) begin
      chk({nm, " fault"}, ld_fault, 1);
      chk({nm, " cause"}, ld_cause, v.cause);
      chk({nm, " flt_req"}, mem.mem_req, 0);
      chk({nm, " flt_wr"}, rd_write_control, 0);
    end else begin
      for (int i = 0; i <= v.gnt_dly; i++) begin
        chk({nm, " req"}, mem.mem_req, 1);
        chk({nm, " addr"}, mem.mem_addr, v.addr);
        chk({nm, " req_stall_pc"}, stall_pc, 1);
        chk({nm, " req_stall_oe"}, stall_other_exec, 1);
        if (i == v.gnt_dly) mem.mem_gnt = 1'b1;
        tick();
      end
      mem.mem_gnt = 1'b0;
      #1;
      chk({nm, " wait_req"}, mem.mem_req, 0);
      for (int i = 0; i < v.rv_dly; i++) begin
        chk({nm, " wait_wr"}, rd_write_control, 0);
        tick();
        #1;
      end
      mem.mem_rvalid = 1'b1; mem.mem_rdata = v.rdata;
      tick();
      mem.mem_rvalid = 1'b0; mem.mem_rdata = 32'hA5A5_5A5A;
      #1;
      chk({nm, " wb_wr"}, rd_write_control, v.wr);
      chk({nm, " wb_rd"}, rd_out, v.rd);
      chk({nm, " wb_val"}, rd_write_val, v.val);
      chk({nm, " wb_stall"}, stall_other_exec, 1);
    end
    tick();
    #1;
    chk_idle({nm, " post"});
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    //          f3      rs1          imm          rd     rdata        g  r  addr    flt cause  wr  val
    vecs[0]  = '{3'b010, 32'h100,     32'h4,        5'd5,  32'hDEADBEEF, 0, 1, 10'h041, 0, 2'b00, 1, 32'hDEADBEEF};
    vecs[1]  = '{3'b000, 32'h200,     32'h3,        5'd7,  32'h80123456, 0, 0, 10'h080, 0, 2'b00, 1, 32'hFFFFFF80};
    vecs[2]  = '{3'b100, 32'h200,     32'h3,        5'd8,  32'h80123456, 1, 0, 10'h080, 0, 2'b00, 1, 32'h00000080};
    vecs[3]  = '{3'b001, 32'h200,     32'h2,        5'd9,  32'h80011234, 0, 2, 10'h080, 0, 2'b00, 1, 32'hFFFF8001};
    vecs[4]  = '{3'b101, 32'h200,     32'h2,        5'd10, 32'h80011234, 0, 0, 10'h080, 0, 2'b00, 1, 32'h00008001};
`ifdef LOAD_MISALIGN_TRAP_EN
    vecs[5]  = '{3'b010, 32'h100,     32'h2,        5'd11, 32'hCAFEF00D, 0, 0, 10'h040, 1, 2'b01, 0, 32'h0};
    vecs[6]  = '{3'b101, 32'h200,     32'h1,        5'd12, 32'hAAAA5555, 0, 0, 10'h080, 1, 2'b01, 0, 32'h0};
`else
    vecs[5]  = '{3'b010, 32'h100,     32'h2,        5'd11, 32'hCAFEF00D, 0, 0, 10'h040, 0, 2'b00, 1, 32'hCAFEF00D};
    vecs[6]  = '{3'b101, 32'h200,     32'h1,        5'd12, 32'hAAAA5555, 0, 0, 10'h080, 0, 2'b00, 1, 32'h00005555};
`endif
    vecs[7]  = '{3'b011, 32'h100,     32'h0,        5'd3,  32'h0,        0, 0, 10'h000, 1, 2'b11, 0, 32'h0};
    vecs[8]  = '{3'b110, 32'h100,     32'h0,        5'd3,  32'h0,        0, 0, 10'h000, 1, 2'b11, 0, 32'h0};
    vecs[9]  = '{3'b010, 32'h300,     32'h0,        5'd0,  32'h12345678, 0, 0, 10'h0C0, 0, 2'b00, 0, 32'h12345678};
    vecs[10] = '{3'b000, 32'h1000,    32'hFFFFFFFF, 5'd1,  32'h7F000000, 0, 0, 10'h3FF, 0, 2'b00, 1, 32'h0000007F};
    vecs[11] = '{3'b001, 32'h10,      32'h0,        5'd31, 32'h1234ABCD, 0, 0, 10'h004, 0, 2'b00, 1, 32'hFFFFABCD};
    vecs[12] = '{3'b100, 32'h4,       32'h1,        5'd2,  32'h0000C300, 0, 0, 10'h001, 0, 2'b00, 1, 32'h000000C3};
    vecs[13] = '{3'b010, 32'h1000,    32'h8,        5'd4,  32'h0BADF00D, 0, 0, 10'h002, 0, 2'b00, 1, 32'h0BADF00D};
    vecs[14] = '{3'b010, 32'h3FC,     32'h0,        5'd6,  32'h55AA55AA, 10, 0, 10'h0FF, 0, 2'b00, 1, 32'h55AA55AA};
    vecs[15] = '{3'b000, 32'h20,      32'h0,        5'd13, 32'h000000FE, 0, 0, 10'h008, 0, 2'b00, 1, 32'hFFFFFFFE};
    vecs[16] = '{3'b000, 32'h20,      32'h2,        5'd14, 32'h00810000, 0, 3, 10'h008, 0, 2'b00, 1, 32'hFFFFFF81};

    i_rst = 1'b1; ld_valid = 1'b0; ld_funct3 = 3'b000; rs1_val = 32'h0; imm = 32'h0; rd_in = 5'd0;
    mem.mem_gnt = 1'b0; mem.mem_rvalid = 1'b0; mem.mem_rdata = 32'hA5A5_5A5A;
    tick();
    tick();
    #1;
    chk_idle("reset");
    chk("reset cause", ld_cause, 0);
    i_rst = 1'b0;
    tick();

    for (int k = 0; k < 17; k++) run_vec(k, vecs[k]);

    // Timeout: grant at once, never return data; fault after exactly 4 WAIT cycles.
    ld_valid = 1'b1; ld_funct3 = 3'b010; rs1_val = 32'h80; imm = 32'h0; rd_in = 5'd9;
    tick();
    ld_valid = 1'b0;
    mem.mem_gnt = 1'b1;
    tick();
    mem.mem_gnt = 1'b0;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk("to wait_fault", ld_fault, 0);
      chk("to wait_wr", rd_write_control, 0);
      chk("to wait_stall", stall_other_exec, 1);
      tick();
    end
    #1;
    chk("to fault", ld_fault, 1);
    chk("to cause", ld_cause, 2'b10);
    chk("to wr", rd_write_control, 0);
    tick();
    #1;
    chk_idle("to post");

    // Reset while waiting for data, then a stray rvalid in IDLE.
    ld_valid = 1'b1; ld_funct3 = 3'b010; rs1_val = 32'h40; imm = 32'h0; rd_in = 5'd7;
    tick();
    ld_valid = 1'b0;
    mem.mem_gnt = 1'b1;
    tick();
    mem.mem_gnt = 1'b0;
    #1;
    chk("rst in_wait", stall_other_exec, 1);
    i_rst = 1'b1;
    tick();
    i_rst = 1'b0;
    #1;
    chk_idle("rst after");
    mem.mem_rvalid = 1'b1; mem.mem_rdata = 32'h11223344;
    tick();
    mem.mem_rvalid = 1'b0;
    #1;
    chk_idle("rst stray");
    tick();
    #1;
    chk_idle("rst stray2");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
